// File: rtl/rs_syndrome_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rs_syndrome_pkg
//  Description : GF(2^m) field constants, FSM encoding and constant-multiply
//                helpers shared by the syndrome and locator blocks.
//  Revision    : 1.0 - initial release
// ============================================================================
package rs_syndrome_pkg;

    localparam int          c_gf_m = 4;
    localparam int unsigned c_gf_f = 'b1001;
    localparam int          c_gf_n = (1 << c_gf_m) - 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // f is the bit pattern of alpha^-1, so the field polynomial is x*f(x)+1;
    // this returns its low w coefficients (the reduction term for x^w).
    function automatic logic [15:0] gf_feedback(input int unsigned f, input int w);
        logic [31:0] t;
        t = (32'(f) << 1) | 32'd1;
        t = t & ((32'd1 << w) - 32'd1);
        return t[15:0];
    endfunction

    // a * alpha^pw; with constant pw this reduces to a fixed XOR network.
    function automatic logic [15:0] gf_mul_alpha_pow(input logic [15:0] a, input int pw,
                                                     input int w, input logic [15:0] fb);
        logic [15:0] v;
        logic [15:0] mask;
        logic        msb;
        mask = 16'((32'd1 << w) - 32'd1);
        v    = a & mask;
        for (int k = 0; k < pw; k++) begin
            msb = |(v & (16'd1 << (w - 1)));
            v   = ((v << 1) & mask) ^ (msb ? fb : 16'd0);
        end
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rs_syn_cell.sv
`default_nettype none
// ============================================================================
//  Module      : rs_syn_cell
//  Description : One Horner accumulator, acc = acc * alpha^POWER ^ sym.
//  Revision    : 1.0 - initial release
// ============================================================================
module rs_syn_cell
    import rs_syndrome_pkg::*;
#(
    parameter int          SYM_W    = c_gf_m,
    parameter int unsigned FEEDBACK = c_gf_f,
    parameter int          POWER    = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_update,
    input  logic [SYM_W-1:0] i_sym,
    output logic [SYM_W-1:0] o_acc_nxt
);

    localparam logic [15:0] c_fb = gf_feedback(FEEDBACK, SYM_W);

    logic [SYM_W-1:0] r_acc;
    logic [SYM_W-1:0] w_prod;

    assign w_prod = SYM_W'(gf_mul_alpha_pow(16'(r_acc), POWER, SYM_W, c_fb));

    always_comb begin
        o_acc_nxt = r_acc;
        if (i_load)
            o_acc_nxt = i_sym;
        else if (i_update)
            o_acc_nxt = w_prod ^ i_sym;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_acc <= '0;
        else
            r_acc <= o_acc_nxt;
    end

endmodule
`default_nettype wire

// File: rtl/rs_syndrome.sv
`default_nettype none
// ============================================================================
//  Module      : rs_syndrome
//  Description : Streams one RS codeword and reports syndromes S1..S4.
//  Revision    : 1.0 - initial release
// ============================================================================
module rs_syndrome
    import rs_syndrome_pkg::*;
#(
    parameter int          m = c_gf_m,
    parameter int unsigned f = c_gf_f
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [m-1:0] in_sym,
    input  logic         in_last,
    output logic         in_ready,
    output logic [m-1:0] S1,
    output logic [m-1:0] S2,
    output logic [m-1:0] S3,
    output logic [m-1:0] S4,
    output logic         syn_valid,
    output logic         no_error,
    output logic         len_err
);

    localparam int                 c_n       = (1 << m) - 1;
    localparam int                 c_cnt_w   = m + 1;
    localparam logic [c_cnt_w-1:0] c_cnt_n   = c_cnt_w'(c_n);
    localparam logic [c_cnt_w-1:0] c_cnt_sat = c_cnt_w'(c_n + 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_in_ready;
    logic               w_accept;
    logic               w_load;
    logic               w_update;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic [m-1:0]       w_acc_nxt [4];
    logic [m-1:0]       r_syn     [4];
    logic               r_syn_valid;
    logic               r_no_error;
    logic               r_len_err;

    assign w_accept = in_valid && r_in_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_update    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_load      = 1'b1;
                    w_state_nxt = in_last ? ST_DONE : ST_ACC;
                end
            end
            ST_ACC: begin
                if (w_accept) begin
                    w_update = 1'b1;
                    if (in_last)
                        w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_load)
            w_cnt_nxt = c_cnt_w'(1);
        else if (w_update && (r_cnt != c_cnt_sat))
            w_cnt_nxt = r_cnt + c_cnt_w'(1);
    end

    for (genvar j = 0; j < 4; j++) begin : g_cell
        rs_syn_cell #(
            .SYM_W    (m),
            .FEEDBACK (f),
            .POWER    (j + 1)
        ) u_cell (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_load    (w_load),
            .i_update  (w_update),
            .i_sym     (in_sym),
            .o_acc_nxt (w_acc_nxt[j])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_in_ready <= (w_state_nxt != ST_DONE);
        end
    end

    // Results are captured on the edge that enters DONE so they are already
    // visible during the DONE cycle, alongside the syn_valid pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int j = 0; j < 4; j++)
                r_syn[j] <= '0;
            r_syn_valid <= 1'b0;
            r_no_error  <= 1'b0;
            r_len_err   <= 1'b0;
        end else begin
            r_syn_valid <= (w_state_nxt == ST_DONE);
            if (w_state_nxt == ST_DONE) begin
                for (int j = 0; j < 4; j++)
                    r_syn[j] <= w_acc_nxt[j];
                r_no_error <= (w_acc_nxt[0] == '0) && (w_acc_nxt[1] == '0) &&
                              (w_acc_nxt[2] == '0) && (w_acc_nxt[3] == '0);
                r_len_err  <= (w_cnt_nxt != c_cnt_n);
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign S1        = r_syn[0];
    assign S2        = r_syn[1];
    assign S3        = r_syn[2];
    assign S4        = r_syn[3];
    assign syn_valid = r_syn_valid;
    assign no_error  = r_no_error;
    assign len_err   = r_len_err;

endmodule
`default_nettype wire

// File: tb/tb_rs_syndrome.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rs_syndrome
//  Description : Self-checking bench for rs_syndrome (GF(16), x^4+x+1).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rs_syndrome;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] in_sym;
    logic       in_last;
    logic       in_ready;
    logic [3:0] S1, S2, S3, S4;
    logic       syn_valid;
    logic       no_error;
    logic       len_err;

    always #5 clk = ~clk;

    rs_syndrome dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_sym    (in_sym),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .S1        (S1),
        .S2        (S2),
        .S3        (S3),
        .S4        (S4),
        .syn_valid (syn_valid),
        .no_error  (no_error),
        .len_err   (len_err)
    );

    int         n_chk   = 0;
    int         n_err   = 0;
    int         n_pulse = 0;
    logic [3:0] word [0:31];
    logic [3:0] h_s  [4];
    logic       h_ne;
    logic       h_le;

    always @(posedge clk)
        if (syn_valid === 1'b1)
            n_pulse <= n_pulse + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Field arithmetic straight from alpha^4 = alpha + 1.
    function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] p = 4'd0;
        logic [3:0] x = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) p ^= x;
            x = {x[2:0], 1'b0} ^ (x[3] ? 4'h3 : 4'h0);
        end
        return p;
    endfunction

    function automatic logic [3:0] gf_pow_alpha(input int e);
        logic [3:0] r = 4'd1;
        for (int i = 0; i < (e % 15); i++) r = gf_mul(r, 4'd2);
        return r;
    endfunction

    // r(alpha^j) as a sum of terms; the first symbol has degree len-1.
    function automatic logic [3:0] model_syn(input int len, input int j);
        logic [3:0] s = 4'd0;
        for (int p = 0; p < len; p++)
            s ^= gf_mul(word[p], gf_pow_alpha((len - 1 - p) * j));
        return s;
    endfunction

    function automatic logic [18:0] obs_vec();
        return {S1, S2, S3, S4, no_error, len_err, syn_valid};
    endfunction

    function automatic logic [18:0] held_vec();
        return {h_s[0], h_s[1], h_s[2], h_s[3], h_ne, h_le, 1'b0};
    endfunction

    task automatic step_hold(input string tag);
        @(posedge clk); #1;
        chk({tag, "/hold"}, 32'(obs_vec()), 32'(held_vec()));
    endtask

    // Drive word[0..len-1]; outputs must stay held with no pulse meanwhile.
    task automatic send_syms(input int len, input bit with_last, input bit gaps, input string tag);
        for (int p = 0; p < len; p++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 3)) step_hold(tag);
            end
            in_valid = 1'b1;
            in_sym   = word[p];
            in_last  = with_last && (p == len - 1);
            begin
                bit acc = 1'b0;
                int w   = 0;
                while (!acc && w < 64) begin
                    acc = in_ready;
                    @(posedge clk); #1;
                    w++;
                    if (!(acc && in_last))
                        chk({tag, "/hold"}, 32'(obs_vec()), 32'(held_vec()));
                end
                chk({tag, "/accept"}, 32'(acc), 32'd1);
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Called in the cycle after the last symbol was accepted.
    task automatic check_result(input int len, input string tag);
        logic [3:0] s [4];
        logic       ne, le;
        for (int j = 0; j < 4; j++) s[j] = model_syn(len, j + 1);
        ne = (s[0] == 0) && (s[1] == 0) && (s[2] == 0) && (s[3] == 0);
        le = (len != 15);
        chk(tag, 32'(obs_vec()), 32'({s[0], s[1], s[2], s[3], ne, le, 1'b1}));
        for (int j = 0; j < 4; j++) h_s[j] = s[j];
        h_ne = ne;
        h_le = le;
    endtask

    task automatic fill_zero(input int len);
        for (int p = 0; p < len; p++) word[p] = 4'd0;
    endtask

    task automatic fill_rand(input int len);
        for (int p = 0; p < len; p++) word[p] = 4'($urandom_range(0, 15));
    endtask

    initial begin
        int exp_pulse;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_sym   = 4'd0;
        in_last  = 1'b0;
        for (int j = 0; j < 4; j++) h_s[j] = 4'd0;
        h_ne = 1'b0;
        h_le = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", 32'({in_ready, obs_vec()}), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_reset", 32'(in_ready), 32'd1);

        // All-zero codeword.
        fill_zero(15);
        send_syms(15, 1'b1, 1'b0, "zero");
        check_result(15, "zero");
        chk("zero_lit", 32'({S1, S2, S3, S4, no_error, len_err}), 32'({16'h0000, 1'b1, 1'b0}));
        step_hold("zero_after");
        chk("zero_pulses", 32'(n_pulse), 32'd1);

        // r[1] = 1.
        fill_zero(15);
        word[13] = 4'd1;
        send_syms(15, 1'b1, 1'b0, "r1");
        check_result(15, "r1");
        chk("r1_lit", 32'({S1, S2, S3, S4, no_error}), 32'({16'h2483, 1'b0}));

        // r[14] = 1.
        fill_zero(15);
        word[0] = 4'd1;
        send_syms(15, 1'b1, 1'b1, "r14");
        check_result(15, "r14");
        chk("r14_lit", 32'({S1, S2, S3, S4}), 32'h9DFE);

        // Random codewords back-to-back with gaps.
        exp_pulse = 3;
        for (int k = 0; k < 4; k++) begin
            fill_rand(15);
            send_syms(15, 1'b1, 1'b1, "b2b");
            check_result(15, "b2b");
            exp_pulse++;
        end
        step_hold("b2b_after");
        chk("b2b_pulses", 32'(n_pulse), 32'(exp_pulse));

        // Short, long, then nominal length.
        fill_rand(10);
        send_syms(10, 1'b1, 1'b1, "len10");
        check_result(10, "len10");
        fill_rand(17);
        send_syms(17, 1'b1, 1'b0, "len17");
        check_result(17, "len17");
        fill_rand(15);
        send_syms(15, 1'b1, 1'b1, "len15");
        check_result(15, "len15");
        fill_rand(1);
        send_syms(1, 1'b1, 1'b0, "len1");
        check_result(1, "len1");
        chk("len1_lit", 32'({S1, S2, S3, S4, len_err}), 32'({word[0], word[0], word[0], word[0], 1'b1}));
        exp_pulse += 4;
        step_hold("len_after");
        chk("len_pulses", 32'(n_pulse), 32'(exp_pulse));

        // Reset in the middle of a codeword.
        fill_rand(7);
        send_syms(7, 1'b0, 1'b1, "abort");
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("mid_reset", 32'({in_ready, obs_vec()}), 32'd0);
        rst_n = 1'b1;
        for (int j = 0; j < 4; j++) h_s[j] = 4'd0;
        h_ne = 1'b0;
        h_le = 1'b0;
        step_hold("post_reset");
        chk("post_reset_ready", 32'(in_ready), 32'd1);
        chk("abort_pulses", 32'(n_pulse), 32'(exp_pulse));
        fill_rand(15);
        send_syms(15, 1'b1, 1'b1, "clean");
        check_result(15, "clean");
        step_hold("clean_after");
        chk("clean_pulses", 32'(n_pulse), 32'(exp_pulse + 1));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
